regfile_mp: RTL

- Parametrised multi-port integer register file with built-in scoreboard; next-generation replacement for the single-read/write-pair register file in the decode stage.
- Supports configurable XLEN, register count, read-port count and write-port count.
- Provides write-to-read bypass across all write ports.
- Tracks per-register "pending write" (busy) bits so decode can detect RAW hazards and stall without a separate hazard unit.
- Sits between decode (read/issue side) and writeback (write side).

---
 rtl/rv_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_mp.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared integer-core definitions: default widths and register-address types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_AW    = $clog2(NREGS_DEF);

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    // Architectural zero register index.
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write (busy) tracking with registered population count.
// Latency: busy and busy_cnt update on the clock edge after issue/write/flush.
// Backpressure: none; consumers stall on the exported busy bits themselves.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   wr_en/wr_addr   writeback lanes; a write retires the producer of wr_addr
//   iss_en/iss_rd   issuing instruction marks its destination busy
//   flush           clears every busy bit on the next edge (beats issue)
//   busy            busy vector, one bit per register
//   busy_cnt        number of busy registers, registered with busy
module regfile_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NREGS-1:0]  busy,
    output logic [AW:0]       busy_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // Priority, lowest to highest: hold, retire by write, set by issue,
    // zero-register pin, flush. Issue beats retire because the new producer
    // supersedes the one writing back this cycle.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                busy_nxt[wr_addr[i*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Count the next-state vector so busy_cnt lands on the same edge as busy.
    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and RAW scoreboard.
// Latency: reads are combinational (zero cycles); writes/busy land on next edge.
// Backpressure: none; writeback always accepted, decode stalls on rd_busy.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data      NWR writeback lanes, highest lane wins a clash
//   rd_addr/rd_data            NRD combinational read ports with bypass
//   rd_busy                    per read port: source still has a producer
//   iss_en/iss_rd              destination of the instruction issuing now
//   flush                      clear all busy bits (register writes still land)
//   busy_cnt                   number of registers currently busy
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Storage. Lanes are applied in index order so the last non-blocking
    // assignment (highest lane) wins when two lanes hit the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] &&
                    !((ZERO_REG != 0) && (wr_addr[i*AW +: AW] == '0))) begin
                    regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Read ports: zero register, then same-cycle bypass, then storage.
    // A bypassed source is never reported busy: its value is on the bus now.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] byp;

        assign ra = rd_addr[p*AW +: AW];

        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (wr_addr[i*AW +: AW] == ra)) begin
                    hit = 1'b1;
                    byp = wr_data[i*XLEN +: XLEN];
                end
            end
        end

        always_comb begin
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_busy[p]              = 1'b0;
            end else if (hit) begin
                rd_data[p*XLEN +: XLEN] = byp;
                rd_busy[p]              = 1'b0;
            end else begin
                rd_data[p*XLEN +: XLEN] = regs[ra];
                rd_busy[p]              = busy[ra];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

endmodule
